data_stack: RTL and testbench

Registered top-of-stack (T), next-on-stack (N) and the spill memory beneath them for the 16-bit Forth datapath. It sits directly downstream of the shifter. The shifter's 16-bit result is the only source written into T, and T/N feed back to the ALU operand inputs. Push/pop bookkeeping, depth counting and sticky overflow/underflow detection all live here.

---
 rtl/data_stack.sv | 134 +++++++++++++
 tb/tb_data_stack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_stack.sv
// ============================================================================
//  Module   : data_stack
//  Purpose  : Registered T/N pair with a spill memory beneath N, depth counter
//             and sticky overflow/underflow flags for the 16-bit Forth datapath.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         result,
    input  logic                     t_we,
    input  logic [1:0]               d_op,
    input  logic                     clr,
    output logic [WIDTH-1:0]         tos,
    output logic [WIDTH-1:0]         nos,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    localparam logic [1:0] C_OP_PUSH  = 2'b01;
    localparam logic [1:0] C_OP_POP   = 2'b10;
    localparam logic [1:0] C_OP_NLOAD = 2'b11;

    localparam logic [SPW-1:0] C_SP_FULL = SPW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_tos;
    logic [WIDTH-1:0] r_nos;
    logic [SPW-1:0]   r_sp;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_nos_next;
    logic [SPW-1:0]   w_sp_next;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_mem_we;
    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == C_SP_FULL);
    assign w_wr_idx = r_sp[AW-1:0];
    // Only consulted when sp is non-zero, so the modulo wrap at sp=DEPTH is harmless.
    assign w_rd_idx = r_sp[AW-1:0] - AW'(1);

    always_comb begin
        w_nos_next = r_nos;
        w_sp_next  = r_sp;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        w_mem_we   = 1'b0;
        case (d_op)
            C_OP_PUSH: begin
                w_nos_next = r_tos;
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_mem_we  = 1'b1;
                    w_sp_next = r_sp + SPW'(1);
                end
            end
            C_OP_POP: begin
                if (w_empty) begin
                    w_nos_next = '0;
                    w_unf_set  = 1'b1;
                end else begin
                    w_nos_next = r_mem[w_rd_idx];
                    w_sp_next  = r_sp - SPW'(1);
                end
            end
            C_OP_NLOAD: begin
                w_nos_next = r_tos;
            end
            default: ;
        endcase
        // Clear wins over any depth change, flag set or spill write this cycle.
        if (clr) begin
            w_sp_next = '0;
            w_ovf_set = 1'b0;
            w_unf_set = 1'b0;
            w_mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tos <= '0;
            r_nos <= '0;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (t_we) begin
                r_tos <= result;
            end
            r_nos <= w_nos_next;
            r_sp  <= w_sp_next;
            r_ovf <= clr ? 1'b0 : (r_ovf | w_ovf_set);
            r_unf <= clr ? 1'b0 : (r_unf | w_unf_set);
        end
    end

    // Spill memory carries no reset; entries at or above sp are unreachable.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= r_nos;
        end
    end

    assign tos   = r_tos;
    assign nos   = r_nos;
    assign depth = r_sp;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_data_stack.sv
// ============================================================================
//  Module   : tb_data_stack
//  Purpose  : Self-checking bench for data_stack against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    localparam logic [1:0] HOLD  = 2'b00;
    localparam logic [1:0] PUSH  = 2'b01;
    localparam logic [1:0] POP   = 2'b10;
    localparam logic [1:0] NLOAD = 2'b11;

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH-1:0]       result;
    logic                   t_we;
    logic [1:0]             d_op;
    logic                   clr;
    logic [WIDTH-1:0]       tos;
    logic [WIDTH-1:0]       nos;
    logic [$clog2(DEPTH):0] depth;
    logic                   empty;
    logic                   full;
    logic                   ovf;
    logic                   unf;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .result (result),
        .t_we   (t_we),
        .d_op   (d_op),
        .clr    (clr),
        .tos    (tos),
        .nos    (nos),
        .depth  (depth),
        .empty  (empty),
        .full   (full),
        .ovf    (ovf),
        .unf    (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: T, N, and the spill area as a LIFO queue.
    logic [WIDTH-1:0] m_t;
    logic [WIDTH-1:0] m_n;
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    logic             m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t   = '0;
        m_n   = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic [WIDTH-1:0] res, input logic we,
                              input logic [1:0] op, input logic c);
        logic [WIDTH-1:0] n_new;
        logic             o_set;
        logic             u_set;
        n_new = m_n;
        o_set = 1'b0;
        u_set = 1'b0;
        case (op)
            PUSH: begin
                if (m_q.size() < DEPTH) m_q.push_back(m_n);
                else o_set = 1'b1;
                n_new = m_t;
            end
            POP: begin
                if (m_q.size() > 0) n_new = m_q.pop_back();
                else begin
                    n_new = '0;
                    u_set = 1'b1;
                end
            end
            NLOAD: n_new = m_t;
            default: ;
        endcase
        if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = m_ovf | o_set;
            m_unf = m_unf | u_set;
        end
        if (we) m_t = res;
        m_n = n_new;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tos"},   32'(tos),   32'(m_t));
        chk({tag, ".nos"},   32'(nos),   32'(m_n));
        chk({tag, ".depth"}, 32'(depth), 32'(m_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(m_q.size() == DEPTH));
        chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        chk({tag, ".unf"},   32'(unf),   32'(m_unf));
    endtask

    // One clocked operation: drive, clock, update model, sample 1 ns later.
    task automatic step(input string tag, input logic [WIDTH-1:0] res, input logic we,
                        input logic [1:0] op, input logic c);
        result = res;
        t_we   = we;
        d_op   = op;
        clr    = c;
        @(posedge clk);
        model_step(res, we, op, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        result = WIDTH'($urandom);
        t_we   = 1'b1;
        d_op   = PUSH;
        clr    = 1'b0;
        model_reset();

        // Reset held with random activity on the inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            result = WIDTH'($urandom);
            t_we   = 1'($urandom);
            d_op   = 2'($urandom);
            clr    = 1'($urandom);
            #1;
            check_all("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("hold", WIDTH'($urandom), 1'b0, HOLD, 1'b0);

        // Basic push/pop
        step("push1", 16'h0001, 1'b1, PUSH, 1'b0);
        step("push2", 16'h0002, 1'b1, PUSH, 1'b0);
        step("push3", 16'h0003, 1'b1, PUSH, 1'b0);
        chk("pp.tos", 32'(tos), 32'h3);
        chk("pp.nos", 32'(nos), 32'h2);
        step("pop1", 16'h00FF, 1'b1, POP, 1'b0);
        chk("pop.tos", 32'(tos), 32'hFF);
        chk("pop.nos", 32'(nos), 32'h1);

        // Overflow then LIFO drain
        step("clr0", 16'h0000, 1'b0, HOLD, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) step("ovf_push", WIDTH'(i), 1'b1, PUSH, 1'b0);
        chk("ovf.full", 32'(full), 32'h1);
        chk("ovf.depth", 32'(depth), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step("ovf_pop", WIDTH'($urandom), 1'b0, POP, 1'b0);
        chk("drain.empty", 32'(empty), 32'h1);
        step("drain_unf", 16'h0, 1'b0, POP, 1'b0);

        // Underflow from reset
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("rst2");
        rst_n = 1'b1;
        @(negedge clk);
        step("unf_pop", 16'h0, 1'b0, POP, 1'b0);
        chk("unf.flag", 32'(unf), 32'h1);
        step("unf_push", 16'h0042, 1'b1, PUSH, 1'b0);
        chk("unf.sticky", 32'(unf), 32'h1);
        step("unf_clr", 16'h0, 1'b0, HOLD, 1'b1);

        // Clear together with PUSH at depth 5
        for (int i = 0; i < 5; i++) step("d5_push", WIDTH'(16'h100 + i), 1'b1, PUSH, 1'b0);
        step("clr_push", 16'h0777, 1'b1, PUSH, 1'b1);
        chk("clr_push.nos", 32'(nos), 32'h104);

        // NLOAD with simultaneous T load
        step("t1234", 16'h1234, 1'b1, HOLD, 1'b0);
        step("nload", 16'hBEEF, 1'b1, NLOAD, 1'b0);
        chk("nload.nos", 32'(nos), 32'h1234);
        chk("nload.tos", 32'(tos), 32'hBEEF);

        // Asynchronous reset between edges during a push burst at depth 7
        step("m_clr", 16'h0, 1'b0, HOLD, 1'b1);
        for (int i = 0; i < 7; i++) step("m_push", WIDTH'($urandom), 1'b1, PUSH, 1'b0);
        result = WIDTH'($urandom);
        t_we   = 1'b1;
        d_op   = PUSH;
        clr    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        #1;
        rst_n = 1'b1;
        step("midrst_pop", 16'h0, 1'b0, POP, 1'b0);
        chk("midrst.unf", 32'(unf), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand", WIDTH'($urandom), 1'($urandom), 2'($urandom),
                 ($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
